// File: rtl/unum4_unpack0_pkg.sv
// rtl/unum4_unpack0_pkg.sv - default unum word geometry shared by the unum4 pack/unpack blocks
package unum4_unpack0_pkg;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_MAN_MAX_W = 29;
   localparam int DEF_EXP_SZ_W  = 4;
   localparam int DEF_EXP_MAX_W = 16;

endpackage

// File: rtl/unum4_unpack0_field_extract.sv
// rtl/unum4_unpack0_field_extract.sv - left-aligns the mantissa field and right-aligns/sign-extends the exponent field by es
module unum4_field_extract
   import unum4_unpack0_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int EXP_SZ_W  = DEF_EXP_SZ_W,
   parameter int EXP_MAX_W = DEF_EXP_MAX_W
) (
   input  logic [DATA_W-EXP_SZ_W-1:0] body_i,
   input  logic [EXP_SZ_W-1:0]        es_i,
   output logic [DATA_W-EXP_SZ_W-1:0] f_left_o,
   output logic [EXP_MAX_W-1:0]       e_ext_o
);

   localparam int BODY_W = DATA_W - EXP_SZ_W;

   logic [EXP_MAX_W-1:0] e_low;
   logic [EXP_MAX_W-1:0] sign_mask;
   logic                 e_neg;
   int unsigned          e_shamt;

   // Body is {E, F}; shifting out the es exponent bits leaves F at the top.
   always_comb begin
      e_shamt   = BODY_W - int'(es_i);
      f_left_o  = body_i << es_i;
      e_low     = EXP_MAX_W'(body_i >> e_shamt);
      e_neg     = (es_i != '0) && body_i[BODY_W-1];
      sign_mask = {EXP_MAX_W{1'b1}} << es_i;
      e_ext_o   = e_neg ? (e_low | sign_mask) : e_low;
   end

endmodule

// File: rtl/unum4_unpack0.sv
// rtl/unum4_unpack0.sv - 3-stage unum word unpacker; UNUM4_UNPACK_FLAGS_EN enables the es/is_zero outputs
module unum4_unpack0
   import unum4_unpack0_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAN_MAX_W = DEF_MAN_MAX_W,
   parameter int EXP_SZ_W  = DEF_EXP_SZ_W,
   parameter int EXP_MAX_W = DEF_EXP_MAX_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATA_W-1:0]    i,
   output logic                 done,
   output logic [EXP_MAX_W-1:0] exp,
   output logic [MAN_MAX_W-1:0] mant,
   output logic [EXP_SZ_W-1:0]  es,
   output logic                 is_zero
);

   localparam int BODY_W = DATA_W - EXP_SZ_W;
   localparam int FLAG_W = EXP_SZ_W + 1;

   logic                 s1_vld_q;
   logic [DATA_W-1:0]    s1_word_q;

   logic [EXP_SZ_W-1:0]  s2_es;
   logic [BODY_W-1:0]    s2_body;
   logic [BODY_W-1:0]    s2_f_left;
   logic [EXP_MAX_W-1:0] s2_e_ext;
   logic [MAN_MAX_W-1:0] s2_mant_d;
   logic [FLAG_W-1:0]    s2_flags_d;

   logic                 s2_vld_q;
   logic [EXP_MAX_W-1:0] s2_e_ext_q;
   logic [MAN_MAX_W-1:0] s2_mant_q;
   logic [FLAG_W-1:0]    s2_flags_q;

   logic                 s3_vld_q;
   logic [EXP_MAX_W-1:0] s3_exp_d;
   logic [EXP_MAX_W-1:0] s3_exp_q;
   logic [MAN_MAX_W-1:0] s3_mant_q;
   logic [FLAG_W-1:0]    s3_flags_q;

   logic [FLAG_W-1:0]    out_flags_q;

   assign s2_es   = s1_word_q[EXP_SZ_W-1:0];
   assign s2_body = s1_word_q[DATA_W-1:EXP_SZ_W];

   unum4_field_extract #(
      .DATA_W    (DATA_W),
      .EXP_SZ_W  (EXP_SZ_W),
      .EXP_MAX_W (EXP_MAX_W)
   ) u_extract (
      .body_i   (s2_body),
      .es_i     (s2_es),
      .f_left_o (s2_f_left),
      .e_ext_o  (s2_e_ext)
   );

   // With es==0 the whole body is mantissa and keeps its own sign; otherwise the hidden MSB is ~F[msb].
   assign s2_mant_d = (s2_es == '0) ? MAN_MAX_W'({s2_body[BODY_W-1], s2_body})
                                    : MAN_MAX_W'({~s2_f_left[BODY_W-1], s2_f_left});

`ifdef UNUM4_UNPACK_FLAGS_EN
   assign s2_flags_d = {s2_es, (s1_word_q == '0)};
`else
   assign s2_flags_d = '0;
`endif

   // Ones'-complement exponent field becomes two's complement by adding 1 when negative.
   assign s3_exp_d = s2_e_ext_q + {{(EXP_MAX_W-1){1'b0}}, s2_e_ext_q[EXP_MAX_W-1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q    <= 1'b0;
         s1_word_q   <= '0;
         s2_vld_q    <= 1'b0;
         s2_e_ext_q  <= '0;
         s2_mant_q   <= '0;
         s2_flags_q  <= '0;
         s3_vld_q    <= 1'b0;
         s3_exp_q    <= '0;
         s3_mant_q   <= '0;
         s3_flags_q  <= '0;
         done        <= 1'b0;
         exp         <= '0;
         mant        <= '0;
         out_flags_q <= '0;
      end else begin
         s1_vld_q   <= start;
         s1_word_q  <= i;
         s2_vld_q   <= s1_vld_q;
         s2_e_ext_q <= s2_e_ext;
         s2_mant_q  <= s2_mant_d;
         s2_flags_q <= s2_flags_d;
         s3_vld_q   <= s2_vld_q;
         s3_exp_q   <= s3_exp_d;
         s3_mant_q  <= s2_mant_q;
         s3_flags_q <= s2_flags_q;
         done       <= s3_vld_q;
         if (s3_vld_q) begin
            exp         <= s3_exp_q;
            mant        <= s3_mant_q;
            out_flags_q <= s3_flags_q;
         end
      end
   end

   assign es      = out_flags_q[FLAG_W-1:1];
   assign is_zero = out_flags_q[0];

endmodule

// File: tb/tb_unum4_unpack0.sv
// tb/tb_unum4_unpack0.sv - directed self-checking bench for unum4_unpack0
module tb_unum4_unpack0;

`ifdef UNUM4_UNPACK_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] i;
   logic        done;
   logic [15:0] exp;
   logic [28:0] mant;
   logic [3:0]  es;
   logic        is_zero;

   int n_cmp;
   int n_bad;

   unum4_unpack0 dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .i       (i),
      .done    (done),
      .exp     (exp),
      .mant    (mant),
      .es      (es),
      .is_zero (is_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] e_exp, input logic [28:0] m_exp,
                          input logic [3:0] es_exp, input logic z_exp);
      chk({tag, " exp"}, 32'(exp), 32'(e_exp));
      chk({tag, " mant"}, 32'(mant), 32'(m_exp));
      chk({tag, " es"}, 32'(es), FLAGS ? 32'(es_exp) : 32'd0);
      chk({tag, " is_zero"}, 32'(is_zero), FLAGS ? 32'(z_exp) : 32'd0);
   endtask

   task automatic send(input string tag, input logic [31:0] word, input logic [15:0] e_exp,
                       input logic [28:0] m_exp, input logic [3:0] es_exp, input logic z_exp);
      @(negedge clk);
      start = 1'b1;
      i     = word;
      @(negedge clk);
      start = 1'b0;
      i     = 32'hDEAD_BEEF;
      chk({tag, " done@N+0"}, 32'(done), 32'd0);
      @(negedge clk);
      chk({tag, " done@N+1"}, 32'(done), 32'd0);
      @(negedge clk);
      chk({tag, " done@N+2"}, 32'(done), 32'd0);
      @(negedge clk);
      chk({tag, " done@N+3"}, 32'(done), 32'd1);
      chk_out(tag, e_exp, m_exp, es_exp, z_exp);
      @(negedge clk);
      chk({tag, " done@N+4"}, 32'(done), 32'd0);
      chk_out({tag, " hold"}, e_exp, m_exp, es_exp, z_exp);
   endtask

   initial begin
      logic [31:0] rt_es;
      logic [31:0] rt_e;
      logic [31:0] rt_f;
      logic [31:0] rt_word;
      logic [31:0] rt_mant;

      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      start = 1'b0;
      i     = 32'h0;
      @(negedge clk);
      @(negedge clk);
      chk("reset done", 32'(done), 32'd0);
      chk_out("reset", 16'h0, 29'h0, 4'd0, 1'b0);
      rst = 1'b0;

      send("zero",      32'h0000_0000, 16'h0000, 29'h0000_0000, 4'd0,  1'b1);
      send("es0 pos",   32'h4000_0000, 16'h0000, 29'h0400_0000, 4'd0,  1'b0);
      send("es2 neg",   32'hA000_0002, 16'hFFFF, 29'h0800_0000, 4'd2,  1'b0);
      send("es3 pos",   32'h6000_0003, 16'h0003, 29'h1000_0000, 4'd3,  1'b0);
      send("es0 neg",   32'h8000_0000, 16'h0000, 29'h1800_0000, 4'd0,  1'b0);
      send("es1 negz",  32'h8000_0001, 16'h0000, 29'h1000_0000, 4'd1,  1'b0);
      send("es15 f",    32'h0001_000F, 16'h0000, 29'h0800_0000, 4'd15, 1'b0);
      send("es15 emax", 32'h7FFE_000F, 16'h3FFF, 29'h1000_0000, 4'd15, 1'b0);
      send("es15 emin", 32'h8000_000F, 16'hC001, 29'h1000_0000, 4'd15, 1'b0);

      // back-to-back: three words on consecutive cycles
      @(negedge clk);
      start = 1'b1;
      i     = 32'h4000_0000;
      @(negedge clk);
      i     = 32'hA000_0002;
      @(negedge clk);
      i     = 32'h6000_0003;
      @(negedge clk);
      start = 1'b0;
      chk("b2b pre", 32'(done), 32'd0);
      @(negedge clk);
      chk("b2b done0", 32'(done), 32'd1);
      chk_out("b2b w0", 16'h0000, 29'h0400_0000, 4'd0, 1'b0);
      @(negedge clk);
      chk("b2b done1", 32'(done), 32'd1);
      chk_out("b2b w1", 16'hFFFF, 29'h0800_0000, 4'd2, 1'b0);
      @(negedge clk);
      chk("b2b done2", 32'(done), 32'd1);
      chk_out("b2b w2", 16'h0003, 29'h1000_0000, 4'd3, 1'b0);
      @(negedge clk);
      chk("b2b done3", 32'(done), 32'd0);

      // reset with two words in flight
      @(negedge clk);
      start = 1'b1;
      i     = 32'hA000_0002;
      @(negedge clk);
      i     = 32'h6000_0003;
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      chk("rst done", 32'(done), 32'd0);
      chk_out("rst clr", 16'h0, 29'h0, 4'd0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rst flush done", 32'(done), 32'd0);
         chk("rst flush mant", 32'(mant), 32'd0);
      end
      send("post rst", 32'h6000_0003, 16'h0003, 29'h1000_0000, 4'd3, 1'b0);

      // round trip through a packing model with nonnegative exponents
      for (int k = 0; k < 8; k++) begin
         rt_es   = $urandom_range(1, 15);
         rt_e    = $urandom_range(0, (32'd1 << (rt_es - 1)) - 1);
         rt_f    = $urandom & ((32'd1 << (28 - rt_es)) - 1);
         rt_word = (rt_e << (32 - rt_es)) | (rt_f << 4) | rt_es;
         rt_mant = (rt_f << rt_es) | ((((rt_f >> (27 - rt_es)) & 32'd1) ^ 32'd1) << 28);
         send("roundtrip", rt_word, rt_e[15:0], rt_mant[28:0], rt_es[3:0], 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/unum4_unpack0.md
UNUM4_UNPACK0 -- requirements
Module: unum4_unpack0

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of the packed unum word.
REQ-002 Parameter MAN_MAX_W, default 29, SHALL set the width of the two's-complement mantissa.
REQ-003 Parameter EXP_SZ_W, default 4, SHALL set the width of the exponent-size field (es).
REQ-004 Parameter EXP_MAX_W, default 16, SHALL set the width of the two's-complement exponent.
REQ-005 clk  input  1  clock; reset rst, synchronous, active-high, SHALL be the only reset.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  packed word on i is valid this cycle.
REQ-008 i  input  DATA_W  packed unum word.
REQ-009 done  output  1  exp/mant/flags valid this cycle.
REQ-010 exp  output  EXP_MAX_W  unpacked two's-complement exponent.
REQ-011 mant  output  MAN_MAX_W  unpacked two's-complement mantissa.
REQ-012 es  output  EXP_SZ_W  exponent-size field of the word.
REQ-013 is_zero  output  1  packed word equals all-zero.

Function
REQ-014 Format: es = i[EXP_SZ_W-1:0]; exponent field E = top es bits i[DATA_W-1 : DATA_W-es]; mantissa field F = i[DATA_W-es-1 : EXP_SZ_W], width DATA_W-EXP_SZ_W-es.
REQ-015 es==0: exp SHALL be 0 and mant SHALL be {i[DATA_W-1], i[DATA_W-1:EXP_SZ_W]}.
REQ-016 es!=0: mant[MAN_MAX_W-2:es] SHALL be F, mant[MAN_MAX_W-1] SHALL be ~F MSB, mant[es-1:0] SHALL be 0.
REQ-017 es!=0: E SHALL be sign-extended to EXP_MAX_W; if its MSB is 1, exp SHALL be the sign-extended value plus 1 (ones'- to two's-complement), else exp SHALL equal it.
REQ-018 Pipeline SHALL be 3 stages: S1 register i/start; S2 decode es and extract E and F (variable shift); S3 exponent correction and output register.
REQ-019 start sampled high at edge N SHALL produce done=1 with valid outputs after edge N+3, for exactly one cycle per start.
REQ-020 Throughput SHALL be one word per cycle; back-to-back starts SHALL yield back-to-back dones in order, with no stall and no back-pressure.
REQ-021 With done=0, exp/mant/es/is_zero SHALL hold their previous values.
REQ-022 Arithmetic SHALL wrap modulo 2^EXP_MAX_W; no saturation.

Reset
REQ-023 rst high at an edge SHALL clear all pipeline valid bits, done, exp, mant, es and is_zero to 0 on that edge.
REQ-024 Words in flight when rst asserts SHALL be discarded; the first done after rst deasserts SHALL be 3 cycles after the first new start.

Configuration
REQ-025 Macro UNUM4_UNPACK_FLAGS_EN defined: es and is_zero SHALL be computed and registered per REQ-012/013.
REQ-026 Macro UNUM4_UNPACK_FLAGS_EN undefined: es and is_zero ports SHALL remain and SHALL be driven constant 0; exp/mant behaviour and latency SHALL be unchanged.

Structure
REQ-027 Shared defs header/package SHALL hold the default widths (DATA_W, MAN_MAX_W, EXP_SZ_W, EXP_MAX_W), shared with unum4_pack0.
REQ-028 The variable-width field extraction (left-aligning F and right-aligning E by es) SHALL be a sub-module named unum4_field_extract; the rest SHALL stay in unum4_unpack0.

Verification (defaults)
REQ-029 i=32'h00000000, start pulse -> 3 cycles later done=1, exp=16'h0000, mant=29'h00000000, es=0, is_zero=1.
REQ-030 i=32'h40000000 (es=0) -> exp=16'h0000, mant=29'h04000000, es=0, is_zero=0.
REQ-031 i=32'hA0000002 (es=2, E=2'b10) -> exp=16'hFFFF, mant=29'h08000000, es=2.
REQ-032 i=32'h60000003 (es=3, E=3'b011) -> exp=16'h0003, mant=29'h10000000, es=3.
REQ-033 Starts on 3 consecutive cycles with words from REQ-030/031/032 -> done high 3 consecutive cycles, outputs in order; and round-trip: random (exp,mant) through unum4_pack0 then unum4_unpack0 -> recovered exp matches for nonnegative exponents, and mant matches on all bits above mant[es-1:0].
REQ-034 rst pulsed one cycle after two starts -> done never asserts for those words; outputs read 0 until the next start completes.
